axil_mem_ctrl: RTL
==================

# axil_mem_ctrl

Memory-stage AXI4-Lite master controller for the pipelined RISC-V core. It sequences one load or store per request onto the AXI4-Lite bus and holds the pipeline through `stall_axi` until the transaction completes. It generates byte strobes and lane-replicated write data from `funct3`, and returns aligned, sign- or zero-extended load data. It sits between the EX/MEM register outputs (`ALUResultM`, `WriteDataM`, `funct3M`) and the external AXI4-Lite slave, and replaces the ad-hoc AXI logic in the datapath.

## Interface
- No parameters. Address decode of the AXI window is done upstream.
- Clock/reset: one clock; reset is synchronous and active-high.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- Memory-stage request:
  - `mem_write` in 1: store request (`AXI_MemWriteM`).
  - `mem_read` in 1: load request (`AXI_MemReadM`).
  - `addr` in 32: byte address (`ALUResultM`).
  - `wdata` in 32: store data, lane 0 aligned (`WriteDataM`).
  - `funct3` in 3: access size and signedness (`funct3M`).
- Pipeline side:
  - `stall_axi` out 1: holds the memory stage and all earlier stages.
  - `rdata_out` out 32: extended load result, held stable until the next load completes.
  - `rdata_valid` out 1: 1-cycle pulse in DONE for loads.
  - `bus_err` out 1: 1-cycle pulse in DONE on SLVERR/DECERR, misalignment or illegal `funct3`.
- AXI4-Lite master:
  - Write address: `awvalid` out 1, `awready` in 1, `awaddr` out 32, `awprot` out 3.
  - Write data: `wvalid` out 1, `wready` in 1, `wdata_o` out 32, `wstrb` out 4.
  - Write response: `bvalid` in 1, `bready` out 1, `bresp` in 2.
  - Read address: `arvalid` out 1, `arready` in 1, `araddr` out 32, `arprot` out 3.
  - Read data: `rvalid` in 1, `rready` out 1, `rdata` in 32, `rresp` in 2.

## Operation
- States:
  - IDLE: waits for a request.
  - WR_AW_W: address and data phases of a write.
  - WR_RESP: waits for the write response.
  - RD_AR: read address phase.
  - RD_DATA: waits for read data.
  - DONE: one-cycle completion state.
- IDLE transitions:
  - `mem_write` → WR_AW_W.
  - Otherwise `mem_read` → RD_AR.
  - If both are asserted, the write wins and no read is issued.
- Request checks in IDLE, before any transition:
  - Misaligned access: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Illegal `funct3`: 011, 110, 111.
  - Either condition → DONE with error. No AXI activity, the store is suppressed, and `rdata_out` is loaded with 0 for loads.
- WR_AW_W:
  - `awvalid` and `wvalid` assert together.
  - Each valid drops independently on its own handshake; completion is tracked with `aw_done` and `w_done` flags.
  - Move to WR_RESP when both phases are done, including the case where both handshakes occur in the same cycle.
- WR_RESP: `bready`=1. On `bvalid`, latch `bresp` and go to DONE.
- RD_AR: `arvalid`=1. On `arready`, go to RD_DATA.
- RD_DATA: `rready`=1. On `rvalid`, capture the extended `rdata` into `rdata_out`, latch `rresp`, and go to DONE.
- DONE:
  - `stall_axi`=0.
  - `rdata_valid`=1 for loads.
  - `bus_err`=1 if the latched response ≠00 or the request failed the IDLE checks.
  - Unconditional return to IDLE. The request still visible on the inputs is ignored, because it is the same instruction.
- Address: `awaddr`/`araddr` = {`addr[31:2]`, 2'b00}, latched on the IDLE exit. `awprot` = `arprot` = 3'b000.
- Write strobes and data (`funct3[1:0]`):
  - 00 (byte): `wstrb` = 4'b0001<<`addr[1:0]`; `wdata_o` = {4{`wdata[7:0]`}}.
  - 01 (halfword): `wstrb` = 4'b0011<<(2·`addr[1]`); `wdata_o` = {2{`wdata[15:0]`}}.
  - 10 (word): `wstrb` = 4'b1111; `wdata_o` = `wdata`.
- Load extraction: select the byte or halfword lane by `addr[1:0]`.
  - 000: sign-extend byte.
  - 001: sign-extend halfword.
  - 010: full word.
  - 100: zero-extend byte.
  - 101: zero-extend halfword.
- A load with an error response still returns the extended `rdata`.

## Timing
- `stall_axi` is combinational: 1 when state ∉ {IDLE, DONE}, or when state = IDLE and a request is present. It never rises later than the cycle the request first appears.
- All other outputs are registered.
- Reset values:
  - All valids, `bready`, `rready`, `rdata_valid` and `bus_err` are 0.
  - `awaddr`, `araddr`, `wdata_o` and `rdata_out` are 0.
  - `wstrb` is 0; `awprot` and `arprot` are 0.
  - State is IDLE.
- Minimum latency with zero-wait slaves is 3 stall cycles, with DONE in cycle 3:
  - Write: request in cycle 0; AW and W handshake in cycle 1; B in cycle 2; DONE in cycle 3.
  - Read: request in cycle 0; AR in cycle 1; R in cycle 2; DONE in cycle 3.
- Each cycle of slave wait adds one stall cycle.
- Valid signals never drop before their handshake.
- Reset mid-transaction clears all outputs and the state on the next edge. The slave is not waited on.

## Test plan
- SW to 0x4000_0010 with data 0xDEADBEEF, zero-wait slave:
  - Cycle 1: `awaddr`=0x4000_0010, `wstrb`=1111.
  - Stall lasts 3 cycles; DONE in cycle 3 with `bus_err`=0.
- SB to 0x4000_0013 with `wdata`=0x000000A5:
  - `wstrb`=1000, `wdata_o`=0xA5A5A5A5.
- LB and LHU from 0x4000_0002, slave returns 0x80F1_7F00:
  - LB: `rdata_out`=0xFFFFFFF1.
  - LHU: `rdata_out`=0x000080F1.
  - `rdata_valid` pulses once per load.
- `awready` delayed 4 cycles while `wready` is immediate:
  - `wvalid` drops after 1 cycle, `awvalid` stays high 5 cycles.
  - Exactly one B phase; stall lasts 7 cycles.
- LW from 0x4000_0006:
  - No `arvalid` is issued.
  - DONE follows the request cycle, with `bus_err`=1 and `rdata_out`=0.
- Read returns `rresp`=10 → `bus_err` pulses in DONE.
- Reset asserted during RD_DATA → next cycle `rready`=0 and `stall_axi`=0 with no request.

Source files
------------

// File: rtl/axil_mem_ctrl.sv
// Memory-stage AXI4-Lite master: one load or store per request, pipeline held via stall_axi.
// Builds lane strobes/replicated store data and returns aligned, extended load data.
module axil_mem_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic        stall_axi,
  output logic [31:0] rdata_out,
  output logic        rdata_valid,
  output logic        bus_err,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic [2:0]  awprot,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [2:0]  arprot,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_AW_W, S_WR_RESP, S_RD_AR, S_RD_DATA, S_DONE
  } state_t;

  state_t      state;
  logic        aw_done;
  logic        w_done;
  logic [1:0]  lane;
  logic [2:0]  op;

  logic        req_c;
  logic        illegal_c;
  logic        misaligned_c;
  logic        req_err_c;
  logic        aw_hs_c;
  logic        w_hs_c;
  logic [3:0]  strb_c;
  logic [31:0] wlane_c;
  logic [7:0]  ld_byte_c;
  logic [15:0] ld_half_c;
  logic [31:0] ld_ext_c;

  assign awprot = 3'b000;
  assign arprot = 3'b000;

  assign req_c     = mem_write | mem_read;
  assign stall_axi = (state == S_IDLE) ? req_c : (state != S_DONE);
  assign aw_hs_c   = awvalid & awready;
  assign w_hs_c    = wvalid & wready;

  // Request legality: size/alignment and reserved encodings
  always_comb begin
    illegal_c    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    misaligned_c = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    req_err_c    = illegal_c | misaligned_c;
  end

  // Store lane strobes and replicated data
  always_comb begin
    strb_c  = 4'b1111;
    wlane_c = wdata;
    case (funct3[1:0])
      2'b00: begin
        strb_c  = 4'b0001 << addr[1:0];
        wlane_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        strb_c  = addr[1] ? 4'b1100 : 4'b0011;
        wlane_c = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane select and extension, using the request latched at issue
  always_comb begin
    ld_byte_c = rdata[7:0];
    case (lane)
      2'b01:   ld_byte_c = rdata[15:8];
      2'b10:   ld_byte_c = rdata[23:16];
      2'b11:   ld_byte_c = rdata[31:24];
      default: ;
    endcase
    ld_half_c = lane[1] ? rdata[31:16] : rdata[15:0];
    ld_ext_c  = rdata;
    case (op)
      3'b000:  ld_ext_c = {{24{ld_byte_c[7]}}, ld_byte_c};
      3'b001:  ld_ext_c = {{16{ld_half_c[15]}}, ld_half_c};
      3'b100:  ld_ext_c = {24'h000000, ld_byte_c};
      3'b101:  ld_ext_c = {16'h0000, ld_half_c};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      lane        <= 2'b00;
      op          <= 3'b000;
      awvalid     <= 1'b0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      awaddr      <= 32'h0;
      araddr      <= 32'h0;
      wdata_o     <= 32'h0;
      wstrb       <= 4'h0;
      rdata_out   <= 32'h0;
      rdata_valid <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      bus_err     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_c) begin
            lane <= addr[1:0];
            op   <= funct3;
            if (req_err_c) begin
              // Rejected request: no bus traffic, report in DONE
              state       <= S_DONE;
              bus_err     <= 1'b1;
              rdata_valid <= ~mem_write;
              if (!mem_write) rdata_out <= 32'h0;
            end else if (mem_write) begin
              state   <= S_WR_AW_W;
              awaddr  <= {addr[31:2], 2'b00};
              wstrb   <= strb_c;
              wdata_o <= wlane_c;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
            end else begin
              state   <= S_RD_AR;
              araddr  <= {addr[31:2], 2'b00};
              arvalid <= 1'b1;
            end
          end
        end
        S_WR_AW_W: begin
          if (aw_hs_c) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs_c) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if ((aw_done | aw_hs_c) && (w_done | w_hs_c)) begin
            state  <= S_WR_RESP;
            bready <= 1'b1;
          end
        end
        S_WR_RESP: begin
          if (bvalid) begin
            bready  <= 1'b0;
            bus_err <= (bresp != 2'b00);
            state   <= S_DONE;
          end
        end
        S_RD_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (rvalid) begin
            rready      <= 1'b0;
            rdata_out   <= ld_ext_c;
            rdata_valid <= 1'b1;
            bus_err     <= (rresp != 2'b00);
            state       <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
